// File: rtl/snappy_ctrl_pkg.sv
// snappy_ctrl_pkg: shared scheduler state encoding and default sizing
package snappy_ctrl_pkg;
    localparam int DEF_NUM_PARSER = 6;
    localparam int DEF_TOKEN_W    = 64;
    localparam int DEF_ID_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first free requester at or above ptr, wrapping back to 0
module rr_picker #(
    parameter int N = 6,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] free_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o
);
    logic [W-1:0] j;

    // Scan N slots starting at ptr; the first free slot wins
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            j = W'((int'(ptr_i) + k) % N);
            if (!found_o && free_i[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end

    assign onehot_o = found_o ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/parser_scheduler.sv
// parser_scheduler: round-robin token dispatch to parsers with page completion tracking
module parser_scheduler
    import snappy_ctrl_pkg::*;
#(
    parameter int NUM_PARSER = DEF_NUM_PARSER,
    parameter int TOKEN_W    = DEF_TOKEN_W,
    parameter int ID_W       = DEF_ID_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  tf_empty,
    input  logic [TOKEN_W-1:0]    tf_dout,
    input  logic                  tf_last,
    output logic                  tf_rd,
    output logic [NUM_PARSER-1:0] ps_valid,
    output logic [TOKEN_W-1:0]    ps_token,
    output logic [ID_W-1:0]       ps_blk_id,
    input  logic [NUM_PARSER-1:0] ps_finish,
    output logic [NUM_PARSER-1:0] busy,
    output logic                  page_input_finish,
    output logic                  page_done,
    output logic                  err
);
    localparam int PW = $clog2(NUM_PARSER);

    state_t                state_q, state_d;
    logic [NUM_PARSER-1:0] busy_q, busy_d, valid_q, valid_d, sel_oh;
    logic [TOKEN_W-1:0]    token_q, token_d;
    logic [ID_W-1:0]       id_q, id_d, blk_q, blk_d;
    logic [PW-1:0]         rr_q, rr_d, sel_idx;
    logic                  pif_q, pif_d, err_q, err_d, found, dispatch, begin_page;

    rr_picker #(.N(NUM_PARSER), .W(PW)) u_pick (
        .free_i   (~busy_q),
        .ptr_i    (rr_q),
        .found_o  (found),
        .onehot_o (sel_oh),
        .idx_o    (sel_idx)
    );

    // A parser finishing this cycle stays busy until next cycle, so only busy_q gates the pick
    assign dispatch   = rst_n && state_q == RUN && !tf_empty && found;
    assign begin_page = state_q == IDLE && start;

    // Next-state for page FSM, dispatch datapath and occupancy
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (dispatch && tf_last) ? DRAIN : RUN;
            DRAIN:   state_d = (busy_q == '0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        busy_d  = (busy_q & ~ps_finish) | (dispatch ? sel_oh : '0);
        valid_d = dispatch ? sel_oh : '0;
        token_d = dispatch ? tf_dout : token_q;
        id_d    = dispatch ? blk_q : id_q;
        blk_d   = begin_page ? '0 : dispatch ? blk_q + 1'b1 : blk_q;
        rr_d    = begin_page ? '0 : !dispatch ? rr_q :
                  (sel_idx == PW'(NUM_PARSER - 1)) ? '0 : sel_idx + 1'b1;
        pif_d   = (dispatch && tf_last) ? 1'b1 : (state_q == DONE) ? 1'b0 : pif_q;
        err_d   = err_q | (|(ps_finish & ~busy_q));
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= '0;
            valid_q <= '0;
            token_q <= '0;
            id_q    <= '0;
            blk_q   <= '0;
            rr_q    <= '0;
            pif_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            token_q <= token_d;
            id_q    <= id_d;
            blk_q   <= blk_d;
            rr_q    <= rr_d;
            pif_q   <= pif_d;
            err_q   <= err_d;
        end
    end

    assign tf_rd             = dispatch;
    assign ps_valid          = valid_q;
    assign ps_token          = token_q;
    assign ps_blk_id         = id_q;
    assign busy              = busy_q;
    assign page_input_finish = pif_q;
    assign page_done         = state_q == DONE;
    assign err               = err_q;
endmodule

// File: tb/tb_parser_scheduler.sv
// tb_parser_scheduler: scoreboard bench for the parser dispatch scheduler
module tb_parser_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tf_empty = 1'b1;
    logic        tf_last = 1'b0;
    logic [63:0] tf_dout = '0;
    logic [5:0]  ps_finish = '0;
    logic        tf_rd;
    logic [5:0]  ps_valid, busy;
    logic [63:0] ps_token;
    logic [7:0]  ps_blk_id;
    logic        page_input_finish, page_done, err;

    typedef struct {
        logic [5:0]  v;
        logic [63:0] tok;
        logic [7:0]  id;
    } exp_t;

    exp_t        sb[$];
    logic [64:0] fifo[$];
    logic [5:0]  seen_v[$];
    logic [7:0]  seen_id[$];
    int          seen_cyc[$];

    int   total = 0, bad = 0;
    int   cyc = 0, pd_cnt = 0, pd_cyc = 0, f_cyc = 0;
    logic armed = 1'b0, pop_pend = 1'b0, auto_fin = 1'b0;

    int         m_st = 0, m_rr = 0;
    logic [5:0] m_busy = '0;
    logic [7:0] m_blk = '0;
    logic       m_pif = 1'b0, m_err = 1'b0;

    parser_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .tf_empty          (tf_empty),
        .tf_dout           (tf_dout),
        .tf_last           (tf_last),
        .tf_rd             (tf_rd),
        .ps_valid          (ps_valid),
        .ps_token          (ps_token),
        .ps_blk_id         (ps_blk_id),
        .ps_finish         (ps_finish),
        .busy              (busy),
        .page_input_finish (page_input_finish),
        .page_done         (page_done),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        tf_empty = fifo.size() == 0;
        if (tf_empty) begin
            tf_last = 1'b0;
            tf_dout = '0;
        end else begin
            {tf_last, tf_dout} = fifo[0];
        end
    endtask

    task automatic push(input logic [63:0] t, input logic l);
        fifo.push_back({l, t});
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (pop_pend && fifo.size() > 0) fifo.delete(0);
        refresh();
        start = 1'b0;
        ps_finish = auto_fin ? busy : '0;
    endtask

    // Reference model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        logic [5:0] free, oh;
        int         sel;
        logic       disp;
        exp_t       e;
        if (armed) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ps_valid", 64'(ps_valid), 64'(e.v));
                check("ps_token", ps_token, e.tok);
                check("ps_blk_id", 64'(ps_blk_id), 64'(e.id));
                seen_v.push_back(ps_valid);
                seen_id.push_back(ps_blk_id);
                seen_cyc.push_back(cyc);
            end else begin
                check("ps_valid_idle", 64'(ps_valid), 64'd0);
            end
            check("busy", 64'(busy), 64'(m_busy));
            check("page_input_finish", 64'(page_input_finish), 64'(m_pif));
            check("page_done", 64'(page_done), 64'(m_st == 3));
            check("err", 64'(err), 64'(m_err));
            if (page_done) begin
                pd_cnt++;
                pd_cyc = cyc;
            end
        end
        free = ~m_busy;
        sel  = 0;
        oh   = '0;
        disp = rst_n && m_st == 1 && !tf_empty && free != 6'd0;
        if (disp) begin
            for (int k = 0; k < 6; k++) begin
                if (oh == 6'd0 && free[(m_rr + k) % 6]) begin
                    sel = (m_rr + k) % 6;
                    oh  = 6'd1 << sel;
                end
            end
        end
        check("tf_rd", 64'(tf_rd), 64'(disp));
        pop_pend = disp;
        if (!rst_n) begin
            m_st = 0;
            m_rr = 0;
            m_busy = '0;
            m_blk = '0;
            m_pif = 1'b0;
            m_err = 1'b0;
            sb.delete();
            armed = 1'b1;
        end else begin
            if (disp) begin
                e.v = oh;
                e.tok = tf_dout;
                e.id = m_blk;
                sb.push_back(e);
            end
            m_err = m_err | (|(ps_finish & free));
            case (m_st)
                0: if (start) begin
                    m_st = 1;
                    m_blk = '0;
                    m_rr = 0;
                end
                1: if (disp && tf_last) m_st = 2;
                2: if (m_busy == 6'd0) m_st = 3;
                default: begin
                    m_st = 0;
                    m_pif = 1'b0;
                end
            endcase
            if (disp) begin
                m_blk++;
                m_rr = (sel + 1) % 6;
                if (tf_last) m_pif = 1'b1;
            end
            m_busy = (m_busy & ~ps_finish) | oh;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(ps_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_tf_rd", 64'(tf_rd), 64'd0);

        // three tokens, parsers never finish
        for (int i = 0; i < 3; i++) push({$urandom, $urandom}, i == 2);
        start = 1'b1;
        repeat (8) tick();
        check("t1_count", 64'(seen_v.size()), 64'd3);
        check("t1_v0", 64'(seen_v[0]), 64'h01);
        check("t1_v1", 64'(seen_v[1]), 64'h02);
        check("t1_v2", 64'(seen_v[2]), 64'h04);
        check("t1_id0", 64'(seen_id[0]), 64'd0);
        check("t1_id2", 64'(seen_id[2]), 64'd2);
        check("t1_busy", 64'(busy), 64'h07);
        check("t1_pif", 64'(page_input_finish), 64'd1);
        check("t1_no_done", 64'(pd_cnt), 64'd0);
        push({$urandom, $urandom}, 1'b0);
        repeat (3) tick();
        check("t1_drain_hold", 64'(fifo.size()), 64'd1);

        // final finish at F gives page_done at F+2
        ps_finish = 6'b000111;
        f_cyc = cyc;
        for (int i = 0; i < 20 && pd_cnt == 0; i++) tick();
        check("t2_done_seen", 64'(pd_cnt), 64'd1);
        check("t2_done_at", 64'(pd_cyc), 64'(f_cyc + 2));
        check("t2_pif_low", 64'(page_input_finish), 64'd0);
        repeat (3) tick();
        check("t2_no_pop", 64'(fifo.size()), 64'd1);

        // fill all parsers, then single finish and wrap of the pointer
        seen_v.delete();
        seen_id.delete();
        seen_cyc.delete();
        for (int i = 0; i < 8; i++) push({$urandom, $urandom}, i == 7);
        start = 1'b1;
        repeat (5) tick();
        start = 1'b1;
        repeat (5) tick();
        check("t3_all_busy", 64'(busy), 64'h3f);
        check("t3_stall", 64'(tf_rd), 64'd0);
        check("t3_waiting", 64'(fifo.size()), 64'd3);
        ps_finish = 6'b001000;
        f_cyc = cyc;
        repeat (4) tick();
        check("t3_v6", 64'(seen_v[6]), 64'h08);
        check("t3_v6_at", 64'(seen_cyc[6]), 64'(f_cyc + 2));
        ps_finish = 6'b100001;
        repeat (5) tick();
        check("t3_v7", 64'(seen_v[7]), 64'h20);
        check("t3_v8", 64'(seen_v[8]), 64'h01);
        check("t3_count", 64'(seen_v.size()), 64'd9);
        ps_finish = 6'h3f;
        for (int i = 0; i < 20 && pd_cnt == 1; i++) tick();
        check("t3_done", 64'(pd_cnt), 64'd2);

        // finish on an idle parser
        tick();
        ps_finish = 6'b000100;
        tick();
        check("t4_err", 64'(err), 64'd1);
        repeat (5) tick();
        check("t4_sticky", 64'(err), 64'd1);

        // long page: block id wraps and one dispatch per cycle
        seen_v.delete();
        seen_id.delete();
        seen_cyc.delete();
        for (int i = 0; i < 300; i++) push({$urandom, $urandom}, i == 299);
        auto_fin = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 400 && pd_cnt == 2; i++) tick();
        auto_fin = 1'b0;
        tick();
        check("t5_done", 64'(pd_cnt), 64'd3);
        check("t5_count", 64'(seen_v.size()), 64'd300);
        check("t5_id255", 64'(seen_id[255]), 64'd255);
        check("t5_id256", 64'(seen_id[256]), 64'd0);
        check("t5_id299", 64'(seen_id[299]), 64'd43);
        check("t5_rate", 64'(seen_cyc[299] - seen_cyc[0]), 64'd299);

        // reset in the middle of DRAIN
        push({$urandom, $urandom}, 1'b1);
        start = 1'b1;
        repeat (4) tick();
        check("t6_pif", 64'(page_input_finish), 64'd1);
        check("t6_busy_pre", 64'(busy != 6'd0), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_err", 64'(err), 64'd0);
        check("t6_pif_clr", 64'(page_input_finish), 64'd0);
        check("t6_valid", 64'(ps_valid), 64'd0);
        push({$urandom, $urandom}, 1'b0);
        repeat (4) tick();
        check("t6_idle", 64'(fifo.size()), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
